fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer for the 1-port synchronous instruction ROM (registered addr + registered q).

---
 rtl/fetch_ctrl.sv | 119 +++++++++++
 tb/tb_fetch_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives a registered-address ROM, waits out
// its read latency and presents each word to decode over valid/ready. Option: PC_WRAP_EN.
module fetch_ctrl #(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ROM_LAT  = 2,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  logic              Start,
  input  logic              Halt,
  output logic [ADDR_W-1:0] RomAddr,
  input  logic [DATA_W-1:0] RomQ,
  output logic [DATA_W-1:0] IR,
  output logic              IrValid,
  input  logic              IrReady,
  output logic [ADDR_W-1:0] PC,
  input  logic              BrEn,
  input  logic [ADDR_W-1:0] BrTarget,
  output logic              Busy,
  output logic              Done
);

  localparam int unsigned CW = (ROM_LAT < 1) ? 1 : $clog2(ROM_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_VALID  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   romaddr_q, romaddr_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [CW-1:0]       latcnt_q, latcnt_d;
  logic [ADDR_W-1:0]   seq_pc;

  assign seq_pc = pc_q + ADDR_W'(1);

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state_q   <= S_IDLE;
      romaddr_q <= '0;
      ir_q      <= '0;
      pc_q      <= '0;
      latcnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      romaddr_q <= romaddr_d;
      ir_q      <= ir_d;
      pc_q      <= pc_d;
      latcnt_q  <= latcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    romaddr_d = romaddr_q;
    ir_d      = ir_q;
    pc_d      = pc_q;
    latcnt_d  = latcnt_q;
    unique case (state_q)
      S_IDLE, S_HALTED: begin
        if (Start && !Halt) begin
          romaddr_d = ADDR_W'(RESET_PC);
          latcnt_d  = '0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (Halt) begin
          latcnt_d = '0;
          state_d  = S_HALTED;
        end else if (latcnt_q == CW'(ROM_LAT)) begin
          ir_d     = RomQ;
          pc_d     = romaddr_q;
          latcnt_d = '0;
          state_d  = S_VALID;
        end else begin
          latcnt_d = latcnt_q + CW'(1);
        end
      end
      S_VALID: begin
        // Halt beats a same-edge accept: the word is consumed but nothing further is fetched.
        if (Halt) begin
          state_d = S_HALTED;
        end else if (IrReady) begin
          latcnt_d = '0;
          if (BrEn) begin
            romaddr_d = BrTarget;
            state_d   = S_WAIT;
          end else if (pc_q == '1) begin
`ifdef PC_WRAP_EN
            romaddr_d = seq_pc;
            state_d   = S_WAIT;
`else
            state_d   = S_HALTED;
`endif
          end else begin
            romaddr_d = seq_pc;
            state_d   = S_WAIT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign RomAddr = romaddr_q;
  assign IR      = ir_q;
  assign PC      = pc_q;
  assign IrValid = (state_q == S_VALID);
  assign Busy    = (state_q == S_WAIT) || (state_q == S_VALID);
  assign Done    = (state_q == S_HALTED);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a two-stage behavioural ROM (q = 16'h1000 + addr).
module tb_fetch_ctrl;
  logic        Clk = 1'b0;
  logic        ResetN, Start, Halt, IrReady, BrEn;
  logic [6:0]  BrTarget;
  logic [6:0]  RomAddr, PC;
  logic [15:0] RomQ, IR;
  logic        IrValid, Busy, Done;
  logic [6:0]  rom_a;

  int unsigned checks = 0;
  int unsigned errors = 0;

  fetch_ctrl #(.ADDR_W(7), .DATA_W(16), .ROM_LAT(2), .RESET_PC(0)) dut (
    .Clk(Clk), .ResetN(ResetN), .Start(Start), .Halt(Halt),
    .RomAddr(RomAddr), .RomQ(RomQ), .IR(IR), .IrValid(IrValid),
    .IrReady(IrReady), .PC(PC), .BrEn(BrEn), .BrTarget(BrTarget),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  // ROM: registered address then registered data, two edges from address change to q
  initial begin rom_a = '0; RomQ = '0; end
  always @(posedge Clk) begin
    rom_a <= RomAddr;
    RomQ  <= 16'h1000 + {9'd0, rom_a};
  end

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [15:0] ir, input logic [6:0] pc,
                           input logic v, input logic b, input logic d);
    chk({tag, ".IR"}, 32'(IR), 32'(ir));
    chk({tag, ".PC"}, 32'(PC), 32'(pc));
    chk({tag, ".IrValid"}, 32'(IrValid), 32'(v));
    chk({tag, ".Busy"}, 32'(Busy), 32'(b));
    chk({tag, ".Done"}, 32'(Done), 32'(d));
  endtask

  initial begin
    ResetN = 1'b0; Start = 1'b0; Halt = 1'b0; IrReady = 1'b0; BrEn = 1'b0; BrTarget = '0;

    // 1: reset, start, first two fetches
    tick(2);
    chk("rst.RomAddr", 32'(RomAddr), 32'd0);
    chk_state("rst", 16'h0000, 7'd0, 1'b0, 1'b0, 1'b0);
    ResetN = 1'b1;
    tick(1);
    chk_state("idle", 16'h0000, 7'd0, 1'b0, 1'b0, 1'b0);
    Start = 1'b1; IrReady = 1'b1;
    tick(1);
    Start = 1'b0;
    chk("e0.RomAddr", 32'(RomAddr), 32'd0);
    chk("e0.Busy", 32'(Busy), 32'd1);
    chk("e0.IrValid", 32'(IrValid), 32'd0);
    tick(1); chk("e1.IrValid", 32'(IrValid), 32'd0);
    tick(1); chk("e2.IrValid", 32'(IrValid), 32'd0);
    tick(1); chk_state("e3", 16'h1000, 7'd0, 1'b1, 1'b1, 1'b0);
    tick(1);
    chk("acc0.IrValid", 32'(IrValid), 32'd0);
    chk("acc0.RomAddr", 32'(RomAddr), 32'd1);
    tick(2); chk("w1.IrValid", 32'(IrValid), 32'd0);
    tick(1); chk_state("f1", 16'h1001, 7'd1, 1'b1, 1'b1, 1'b0);

    // 2: backpressure on word 2
    tick(1);
    IrReady = 1'b0;
    chk("acc1.RomAddr", 32'(RomAddr), 32'd2);
    tick(3);
    chk_state("f2", 16'h1002, 7'd2, 1'b1, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 10; i++) begin
      tick(1);
      chk("bp.hold", {IrValid, RomAddr, PC, IR[15:0]}, {1'b1, 7'd2, 7'd2, 16'h1002});
    end
    IrReady = 1'b1;
    tick(1);
    chk("bp.rel.RomAddr", 32'(RomAddr), 32'd3);
    tick(3);
    chk_state("f3", 16'h1003, 7'd3, 1'b1, 1'b1, 1'b0);

    // 3: branch on accept, branch ignored without accept
    BrEn = 1'b1; BrTarget = 7'h40;
    tick(1);
    BrEn = 1'b0;
    chk("br.RomAddr", 32'(RomAddr), 32'h40);
    tick(3);
    chk_state("f40", 16'h1040, 7'h40, 1'b1, 1'b1, 1'b0);
    IrReady = 1'b0; BrEn = 1'b1; BrTarget = 7'h10;
    tick(2);
    chk("brnoacc.RomAddr", 32'(RomAddr), 32'h40);
    chk_state("brnoacc", 16'h1040, 7'h40, 1'b1, 1'b1, 1'b0);
    BrEn = 1'b0; IrReady = 1'b1;
    tick(1);
    chk("seq41.RomAddr", 32'(RomAddr), 32'h41);

    // 4: halt in WAIT, restart, halt against a same-edge accept
    Halt = 1'b1;
    tick(1);
    Halt = 1'b0;
    chk_state("haltw", 16'h1040, 7'h40, 1'b0, 1'b0, 1'b1);
    tick(3);
    chk_state("halted", 16'h1040, 7'h40, 1'b0, 1'b0, 1'b1);
    Start = 1'b1; Halt = 1'b1;
    tick(1);
    chk("starthalt.Done", 32'(Done), 32'd1);
    Halt = 1'b0;
    tick(1);
    Start = 1'b0;
    chk("restart.RomAddr", 32'(RomAddr), 32'd0);
    chk("restart.Busy", 32'(Busy), 32'd1);
    tick(3);
    chk_state("rf0", 16'h1000, 7'd0, 1'b1, 1'b1, 1'b0);
    Halt = 1'b1;
    tick(1);
    Halt = 1'b0;
    chk("haltacc.RomAddr", 32'(RomAddr), 32'd0);
    chk_state("haltacc", 16'h1000, 7'd0, 1'b0, 1'b0, 1'b1);

    // 5: end of ROM
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
    tick(3);
    chk_state("eor.f0", 16'h1000, 7'd0, 1'b1, 1'b1, 1'b0);
    BrEn = 1'b1; BrTarget = 7'h7F;
    tick(1);
    BrEn = 1'b0;
    chk("eor.RomAddr", 32'(RomAddr), 32'h7F);
    tick(3);
    chk_state("f7f", 16'h107F, 7'h7F, 1'b1, 1'b1, 1'b0);
    tick(1);
`ifdef PC_WRAP_EN
    chk("wrap.RomAddr", 32'(RomAddr), 32'd0);
    chk("wrap.Busy", 32'(Busy), 32'd1);
    tick(3);
    chk_state("wrap.f0", 16'h1000, 7'd0, 1'b1, 1'b1, 1'b0);
`else
    chk("end.RomAddr", 32'(RomAddr), 32'h7F);
    chk_state("end", 16'h107F, 7'h7F, 1'b0, 1'b0, 1'b1);
`endif

    // 6: reset mid-WAIT and mid-VALID
    ResetN = 1'b0;
    tick(1);
    ResetN = 1'b1; Start = 1'b1;
    tick(1);
    Start = 1'b0;
    chk("r6.RomAddr", 32'(RomAddr), 32'd0);
    tick(1);
    ResetN = 1'b0;
    tick(1);
    ResetN = 1'b1;
    chk("rstw.RomAddr", 32'(RomAddr), 32'd0);
    chk_state("rstw", 16'h0000, 7'd0, 1'b0, 1'b0, 1'b0);
    tick(2);
    chk("rstw.noCapture", 32'(IrValid), 32'd0);
    IrReady = 1'b0; Start = 1'b1;
    tick(1);
    Start = 1'b0;
    tick(3);
    chk_state("pre_rstv", 16'h1000, 7'd0, 1'b1, 1'b1, 1'b0);
    ResetN = 1'b0;
    tick(1);
    ResetN = 1'b1;
    chk_state("rstv", 16'h0000, 7'd0, 1'b0, 1'b0, 1'b0);
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
    tick(3);
    chk_state("post_rst", 16'h1000, 7'd0, 1'b1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
